queue_dispatcher: RTL

Write-side counterpart of the weighted round-robin arbiter. It accepts a single incoming byte stream and classifies each word by its destination field. It then pushes the word into one of QUEUE_QUANTITY FIFOs, applying per-queue backpressure. The arbiter drains those same FIFOs on the read side.

---
 rtl/queue_dispatcher_pkg.sv | 26 ++
 rtl/queue_dispatcher_hold_reg.sv | 66 ++++++
 rtl/queue_dispatcher.sv | 122 ++++++++++++
 3 files changed

// File: rtl/queue_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// queue_dispatcher_pkg
// Shared definitions for the queue dispatcher and the weighted round-robin
// arbiter that drains the same FIFOs: queue count, word width, occupancy
// counter width, holding-register state encoding and the destination-field
// extraction helper.
// -----------------------------------------------------------------------------
package queue_dispatcher_pkg;

    localparam int QUEUE_QUANTITY = 4;
    localparam int DATA_BITS      = 8;
    localparam int BUF_WIDTH      = 3;
    localparam int SEL_BITS       = $clog2(QUEUE_QUANTITY);

    // One-entry holding register state.
    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_e;

    // Destination queue lives in the top SEL_BITS of each word.
    function automatic logic [SEL_BITS-1:0] dest_of(input logic [DATA_BITS-1:0] word);
        return word[DATA_BITS-1 -: SEL_BITS];
    endfunction

endpackage

// File: rtl/queue_dispatcher_hold_reg.sv
// -----------------------------------------------------------------------------
// dispatch_hold_reg
// One-entry holding register with valid/ready semantics. A load captures the
// incoming word; a pop or drop empties the entry unless a load replaces it in
// the same cycle. Nothing changes while enb_i is low.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   enb_i    global enable; low freezes the entry
//   load_i   capture data_i this cycle (accept)
//   pop_i    held word is pushed to its FIFO this cycle
//   drop_i   held word is discarded this cycle
//   data_i   incoming word
//   valid_o  entry holds a word
//   data_o   held word
// -----------------------------------------------------------------------------
module dispatch_hold_reg
    import queue_dispatcher_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb_i,
    input  logic                 load_i,
    input  logic                 pop_i,
    input  logic                 drop_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] data_o
);

    hold_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] data_q,  data_d;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (enb_i) begin
            if (load_i) begin
                // Covers both EMPTY->HELD and push-with-replace in HELD.
                state_d = HELD;
                data_d  = data_i;
            end else if (pop_i || drop_i) begin
                state_d = EMPTY;
            end
        end
    end

    assign valid_o = (state_q == HELD);
    assign data_o  = data_q;

endmodule

// File: rtl/queue_dispatcher.sv
// -----------------------------------------------------------------------------
// queue_dispatcher
// Write side of the weighted round-robin queue system. Words from a single
// source stream are held one at a time and pushed into the FIFO named by their
// destination field, honouring per-queue backpressure (full flag or occupancy
// at/above FULL_THRESH). A blocked head word stalls the whole stream, so words
// leave in arrival order. Push and accept may coincide for one word per cycle.
//
// Optional feature (macro QUEUE_DISPATCHER_DROP_EN): a held word whose target
// stays blocked for 4 consecutive enabled cycles is discarded and drop_count
// (saturating at 255) increments. Without the macro the dispatcher stalls
// indefinitely and drop_count does not exist.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   enb           global enable; low freezes all state and zeroes outputs
//   in_valid      source presents a word
//   in_data       incoming word (destination in its top SEL_BITS)
//   in_ready      dispatcher accepts a word this cycle
//   buf_full      per-FIFO full flags
//   fifo_counter  packed per-FIFO occupancy, queue q at [q*BUF_WIDTH +: BUF_WIDTH]
//   fifo_push     one-hot push strobe, or all zero
//   fifo_data     word written to the selected FIFO (0 when no push)
//   stalled       held word is blocked this cycle
//   drop_count    number of dropped words (QUEUE_DISPATCHER_DROP_EN only)
// -----------------------------------------------------------------------------
module queue_dispatcher
    import queue_dispatcher_pkg::*;
#(
    parameter int FULL_THRESH = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic                                in_valid,
    input  logic [DATA_BITS-1:0]                in_data,
    output logic                                in_ready,
    input  logic [QUEUE_QUANTITY-1:0]           buf_full,
    input  logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
    output logic [QUEUE_QUANTITY-1:0]           fifo_push,
    output logic [DATA_BITS-1:0]                fifo_data,
    output logic                                stalled
`ifdef QUEUE_DISPATCHER_DROP_EN
    ,
    output logic [7:0]                          drop_count
`endif
);

    // One extra bit so a threshold of exactly 2^BUF_WIDTH is representable.
    localparam logic [BUF_WIDTH:0] THRESH = (BUF_WIDTH+1)'(FULL_THRESH);

    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;
    logic [SEL_BITS-1:0]  sel;
    logic [BUF_WIDTH-1:0] sel_count;
    logic                 blocked;
    logic                 push_now;
    logic                 accept;
    logic                 drop;

    assign sel       = dest_of(hold_data);
    assign sel_count = fifo_counter[sel*BUF_WIDTH +: BUF_WIDTH];
    assign blocked   = buf_full[sel] || ({1'b0, sel_count} >= THRESH);

    assign push_now  = hold_valid && enb && !blocked;
    assign stalled   = hold_valid && enb && blocked;
    assign in_ready  = enb && !rst && (!hold_valid || push_now);
    assign accept    = in_valid && in_ready;

    assign fifo_push = push_now ? (QUEUE_QUANTITY'(1) << sel) : '0;
    assign fifo_data = push_now ? hold_data : '0;

`ifdef QUEUE_DISPATCHER_DROP_EN
    // Counts consecutive enabled blocked cycles of the current head word;
    // the 4th such cycle discards it.
    logic [1:0] blk_cnt_q, blk_cnt_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign drop = stalled && (blk_cnt_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        blk_cnt_d  = blk_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (push_now || drop) begin
            blk_cnt_d = '0;
        end else if (stalled) begin
            blk_cnt_d = blk_cnt_q + 2'd1;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop = 1'b0;
`endif

    dispatch_hold_reg u_hold (
        .clk     (clk),
        .rst     (rst),
        .enb_i   (enb),
        .load_i  (accept),
        .pop_i   (push_now),
        .drop_i  (drop),
        .data_i  (in_data),
        .valid_o (hold_valid),
        .data_o  (hold_data)
    );

endmodule
